led_fade: RTL

Slew-rate-limited duty-cycle generator that sits directly upstream of the pwm block and drives its duty_cycle input.
- Accepts a target duty and a per-step rate over a valid/ready handshake.
- Ramps its registered duty output toward the target, one step per prescaled tick.
- Gives smooth LED fades instead of abrupt brightness jumps.

---
 rtl/led_fade_pkg.sv | 20 ++
 rtl/led_fade_tick.sv | 28 ++
 rtl/led_fade.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/led_fade_pkg.sv
// Shared definitions for the led_fade duty-cycle ramp generator.
package led_fade_pkg;

  localparam int RATE_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  function automatic int calc_tick_div(input int clk_freq, input int step_hz);
    return clk_freq / step_hz;
  endfunction

  function automatic int calc_cnt_width(input int tick_div);
    return ($clog2(tick_div) < 1) ? 1 : $clog2(tick_div);
  endfunction

endpackage

// File: rtl/led_fade_tick.sv
// Step prescaler: counts 0..TICK_DIV-1 and flags the last count as tick.
module led_fade_tick #(
  parameter int TICK_DIV = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_fade.sv
// Slew-rate-limited duty generator feeding the pwm block.
// Optional LED_FADE_GAMMA_EN adds a registered d*(d+1)>>W output curve.
module led_fade
  import led_fade_pkg::*;
#(
  parameter int CLK_FREQ         = 50000000,
  parameter int STEP_HZ          = 1000,
  parameter int DUTY_CYCLE_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        tgt_valid,
  output logic                        tgt_ready,
  input  logic [DUTY_CYCLE_WIDTH-1:0] tgt_duty,
  input  logic [RATE_WIDTH-1:0]       tgt_rate,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
  output logic                        busy,
  output logic                        done
);

  localparam int W        = DUTY_CYCLE_WIDTH;
  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, STEP_HZ);
  localparam int CNT_W    = calc_cnt_width(TICK_DIV);
  // Wide enough for a W+1 bit difference and for the full rate value.
  localparam int CW       = (W + 1 > RATE_WIDTH) ? W + 1 : RATE_WIDTH;

  state_t                state_reg, state_next;
  logic [W-1:0]          duty_reg, duty_next;
  logic [W-1:0]          target_reg, target_next;
  logic [RATE_WIDTH-1:0] rate_reg, rate_next;
  logic                  done_reg, done_next;
  logic                  busy_reg;
  logic                  xfer;
  logic                  tick;
  logic [CW-1:0]         gap;
  logic [CW-1:0]         rate_ext;

  assign tgt_ready = (state_reg == S_IDLE);
  assign xfer      = tgt_valid && tgt_ready;
  assign rate_ext  = CW'(rate_reg);

  led_fade_tick #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (xfer),
    .tick (tick)
  );

  always_comb begin
    state_next  = state_reg;
    duty_next   = duty_reg;
    target_next = target_reg;
    rate_next   = rate_reg;
    done_next   = 1'b0;
    gap         = '0;
    case (state_reg)
      S_IDLE: begin
        if (xfer) begin
          target_next = tgt_duty;
          rate_next   = (tgt_rate == '0) ? RATE_WIDTH'(1) : tgt_rate;
          if (tgt_duty > duty_reg) begin
            state_next = S_UP;
          end else if (tgt_duty < duty_reg) begin
            state_next = S_DOWN;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      S_UP: begin
        if (tick) begin
          gap = CW'(target_reg) - CW'(duty_reg);
          // Final step clamps to the target so the ramp never overshoots.
          if (gap <= rate_ext) begin
            duty_next  = target_reg;
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            duty_next = W'(CW'(duty_reg) + rate_ext);
          end
        end
      end
      S_DOWN: begin
        if (tick) begin
          gap = CW'(duty_reg) - CW'(target_reg);
          if (gap <= rate_ext) begin
            duty_next  = target_reg;
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            duty_next = W'(CW'(duty_reg) - rate_ext);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= S_IDLE;
      duty_reg   <= '0;
      target_reg <= '0;
      rate_reg   <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      duty_reg   <= duty_next;
      target_reg <= target_next;
      rate_reg   <= rate_next;
      done_reg   <= done_next;
      busy_reg   <= (state_next != S_IDLE);
    end
  end

`ifdef LED_FADE_GAMMA_EN
  localparam int PW = 2 * W;

  logic [PW-1:0] sq;
  logic [W-1:0]  gamma_reg;
  logic          done_d_reg;
  logic          busy_d_reg;

  assign sq = PW'(duty_reg) * (PW'(duty_reg) + PW'(1));

  // Status is delayed with the curve so it stays aligned with duty_cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gamma_reg  <= '0;
      done_d_reg <= 1'b0;
      busy_d_reg <= 1'b0;
    end else begin
      gamma_reg  <= sq[PW-1:W];
      done_d_reg <= done_reg;
      busy_d_reg <= busy_reg;
    end
  end

  assign duty_cycle = gamma_reg;
  assign busy       = busy_d_reg;
  assign done       = done_d_reg;
`else
  assign duty_cycle = duty_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
`endif

endmodule
